// File: rtl/aibcr3_dll_lock_det.sv
// DLL lock detector: accumulates phase-detector up/down votes over programmable
// windows and asserts a registered, glitch-free dll_lock after N consecutive balanced windows.
module aibcr3_dll_lock_det #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned STB_W = 4
) (
    input  logic       clk_dcd,
    input  logic       RSTb,
    input  logic       dll_en,
    input  logic       pd_up,
    input  logic       pd_dn,
    input  logic [1:0] rb_lock_win,
    input  logic [3:0] rb_lock_tol,
    input  logic [3:0] rb_lock_cnt,
    input  logic       rb_cont_cal,
    output logic       dll_lock,
    output logic [1:0] lock_st,
    output logic       win_done
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACQ    = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;

    localparam int unsigned CMP_W = (STB_W > 4) ? STB_W : 4;

    logic [1:0]       state;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] dn_cnt;
    logic [STB_W-1:0] stb_cnt;

    logic [CNT_W-1:0] len_m1;
    logic [CNT_W-1:0] up_nxt;
    logic [CNT_W-1:0] dn_nxt;
    logic [CNT_W-1:0] diff;
    logic [STB_W-1:0] stb_inc;
    logic [3:0]       need;
    logic             win_end;
    logic             stable;
    logic             lock_hit;

    always_comb begin
        case (rb_lock_win)
            2'd0:    len_m1 = CNT_W'(15);
            2'd1:    len_m1 = CNT_W'(31);
            2'd2:    len_m1 = CNT_W'(63);
            default: len_m1 = CNT_W'(127);
        endcase
    end

    // The closing cycle's own vote is folded in before the window is judged.
    always_comb begin
        up_nxt = up_cnt;
        dn_nxt = dn_cnt;
        if (pd_up && !pd_dn && (up_cnt != '1)) up_nxt = up_cnt + CNT_W'(1);
        if (pd_dn && !pd_up && (dn_cnt != '1)) dn_nxt = dn_cnt + CNT_W'(1);
        diff     = (up_nxt >= dn_nxt) ? (up_nxt - dn_nxt) : (dn_nxt - up_nxt);
        stable   = ((up_nxt | dn_nxt) != '0) && (diff <= CNT_W'(rb_lock_tol));
        win_end  = (win_cnt == len_m1);
        stb_inc  = (stb_cnt == '1) ? stb_cnt : stb_cnt + STB_W'(1);
        need     = (rb_lock_cnt == 4'd0) ? 4'd1 : rb_lock_cnt;
        lock_hit = (CMP_W'(stb_inc) >= CMP_W'(need));
    end

    always_ff @(posedge clk_dcd or negedge RSTb) begin
        if (!RSTb) begin
            state    <= ST_IDLE;
            win_cnt  <= '0;
            up_cnt   <= '0;
            dn_cnt   <= '0;
            stb_cnt  <= '0;
            dll_lock <= 1'b0;
            win_done <= 1'b0;
        end else if (!dll_en || (state == ST_IDLE)) begin
            state    <= dll_en ? ST_ACQ : ST_IDLE;
            win_cnt  <= '0;
            up_cnt   <= '0;
            dn_cnt   <= '0;
            stb_cnt  <= '0;
            dll_lock <= 1'b0;
            win_done <= 1'b0;
        end else if (win_end) begin
            win_cnt  <= '0;
            up_cnt   <= '0;
            dn_cnt   <= '0;
            win_done <= 1'b1;
            if (state == ST_ACQ) begin
                if (stable) begin
                    stb_cnt <= stb_inc;
                    if (lock_hit) begin
                        state    <= ST_LOCKED;
                        dll_lock <= 1'b1;
                    end
                end else begin
                    stb_cnt <= '0;
                end
            end else if (!stable && rb_cont_cal) begin
                state    <= ST_ACQ;
                dll_lock <= 1'b0;
                stb_cnt  <= '0;
            end
        end else begin
            // A window shortened below win_cnt ends only after the counter wraps.
            win_cnt  <= win_cnt + CNT_W'(1);
            up_cnt   <= up_nxt;
            dn_cnt   <= dn_nxt;
            win_done <= 1'b0;
        end
    end

    assign lock_st = state;

endmodule

// File: tb/tb_aibcr3_dll_lock_det.sv
// Self-checking bench for aibcr3_dll_lock_det: directed scenarios plus randomized
// vote streams, each cycle compared against a window-level behavioural model.
module tb_aibcr3_dll_lock_det;

    logic       clk_dcd = 1'b0;
    logic       RSTb = 1'b1;
    logic       dll_en = 1'b0;
    logic       pd_up = 1'b0;
    logic       pd_dn = 1'b0;
    logic [1:0] rb_lock_win = 2'd0;
    logic [3:0] rb_lock_tol = 4'd2;
    logic [3:0] rb_lock_cnt = 4'd3;
    logic       rb_cont_cal = 1'b0;
    logic       dll_lock;
    logic [1:0] lock_st;
    logic       win_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: window position, vote tallies, stable-window run, lock.
    int m_mode = 0;   // 0 idle, 1 acquiring, 2 locked
    int m_pos  = 0;
    int m_up   = 0;
    int m_dn   = 0;
    int m_run  = 0;
    bit m_lock = 1'b0;
    bit m_done = 1'b0;

    aibcr3_dll_lock_det #(.CNT_W(8), .STB_W(4)) dut (
        .clk_dcd     (clk_dcd),
        .RSTb        (RSTb),
        .dll_en      (dll_en),
        .pd_up       (pd_up),
        .pd_dn       (pd_dn),
        .rb_lock_win (rb_lock_win),
        .rb_lock_tol (rb_lock_tol),
        .rb_lock_cnt (rb_lock_cnt),
        .rb_cont_cal (rb_cont_cal),
        .dll_lock    (dll_lock),
        .lock_st     (lock_st),
        .win_done    (win_done)
    );

    always #5 clk_dcd = ~clk_dcd;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_up = 0; m_dn = 0; m_run = 0;
        m_lock = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        int len;
        int need;
        int skew;
        bit ok;
        m_done = 1'b0;
        if (!dll_en) begin
            model_reset();
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1;
            return;
        end
        if (pd_up && !pd_dn) m_up = (m_up < 255) ? m_up + 1 : 255;
        if (pd_dn && !pd_up) m_dn = (m_dn < 255) ? m_dn + 1 : 255;
        len = 16 << rb_lock_win;
        if (m_pos != len - 1) begin
            m_pos = (m_pos + 1) % 256;
            return;
        end
        skew = (m_up > m_dn) ? m_up - m_dn : m_dn - m_up;
        ok   = (m_up + m_dn > 0) && (skew <= int'(rb_lock_tol));
        need = (rb_lock_cnt == 0) ? 1 : int'(rb_lock_cnt);
        m_done = 1'b1;
        m_pos = 0; m_up = 0; m_dn = 0;
        if (m_mode == 1) begin
            if (ok) begin
                m_run = (m_run < 15) ? m_run + 1 : 15;
                if (m_run >= need) begin
                    m_mode = 2;
                    m_lock = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end else if (!ok && rb_cont_cal) begin
            m_mode = 1;
            m_lock = 1'b0;
            m_run  = 0;
        end
    endtask

    // Advance one clock: model consumes the inputs present at the edge.
    task automatic step();
        if (RSTb) model_edge();
        else model_reset();
        @(posedge clk_dcd);
        #1;
    endtask

    task automatic go_idle();
        dll_en = 1'b0;
        pd_up  = 1'b0;
        pd_dn  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #1 RSTb = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if ({dll_lock, lock_st, win_done} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset cyc %0d: got %b want 0000", i, {dll_lock, lock_st, win_done});
            end
        end
        RSTb = 1'b1;
        step();
        n_vec++;
        if ({dll_lock, lock_st, win_done} !== {m_lock, 2'(m_mode), m_done}) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want %b", {dll_lock, lock_st, win_done}, {m_lock, 2'(m_mode), m_done});
        end
    endtask

    task automatic test_basic_lock();
        int lat = 0;
        go_idle();
        rb_lock_win = 2'd0; rb_lock_tol = 4'd2; rb_lock_cnt = 4'd3; rb_cont_cal = 1'b0;
        dll_en = 1'b1;
        for (int i = 0; i < 200 && lat == 0; i++) begin
            pd_up = i[0]; pd_dn = ~i[0];
            step();
            n_vec++;
            if ({dll_lock, lock_st, win_done} !== {m_lock, 2'(m_mode), m_done}) begin
                n_err++;
                $display("FAIL basic cyc %0d: got %b want %b", i, {dll_lock, lock_st, win_done}, {m_lock, 2'(m_mode), m_done});
            end
            if (dll_lock) lat = i + 1;
        end
        n_vec++;
        if (lat != 49 || lock_st !== 2'b10) begin
            n_err++;
            $display("FAIL basic_latency: got %0d st %b want 49 st 10", lat, lock_st);
        end
    endtask

    task automatic test_unbalanced();
        int lat = 0;
        go_idle();
        rb_lock_win = 2'd0; rb_lock_tol = 4'd2; rb_lock_cnt = 4'd3; rb_cont_cal = 1'b0;
        dll_en = 1'b1;
        for (int i = 0; i < 200 && lat == 0; i++) begin
            if (i >= 1 && (i - 1) / 16 == 2 && (i - 1) % 16 >= 12) begin
                pd_up = 1'b1; pd_dn = 1'b0;
            end else begin
                pd_up = i[0]; pd_dn = ~i[0];
            end
            step();
            n_vec++;
            if ({dll_lock, lock_st, win_done} !== {m_lock, 2'(m_mode), m_done}) begin
                n_err++;
                $display("FAIL unbal cyc %0d: got %b want %b", i, {dll_lock, lock_st, win_done}, {m_lock, 2'(m_mode), m_done});
            end
            if (dll_lock) lat = i + 1;
        end
        n_vec++;
        if (lat != 97) begin
            n_err++;
            $display("FAIL unbal_latency: got %0d want 97", lat);
        end
    endtask

    task automatic test_sticky(input bit cont);
        int lat = 0;
        go_idle();
        rb_lock_win = 2'd0; rb_lock_tol = 4'd2; rb_lock_cnt = 4'd1; rb_cont_cal = cont;
        dll_en = 1'b1;
        for (int i = 0; i < 100 && lat == 0; i++) begin
            pd_up = i[0]; pd_dn = ~i[0];
            step();
            if (dll_lock) lat = i + 1;
        end
        for (int i = 0; i < 16; i++) begin
            pd_up = 1'b1; pd_dn = 1'b0;
            step();
            n_vec++;
            if ({dll_lock, lock_st, win_done} !== {m_lock, 2'(m_mode), m_done}) begin
                n_err++;
                $display("FAIL sticky%0d cyc %0d: got %b want %b", cont, i, {dll_lock, lock_st, win_done}, {m_lock, 2'(m_mode), m_done});
            end
        end
        n_vec++;
        if (lat != 17 || {dll_lock, lock_st} !== (cont ? 3'b001 : 3'b110)) begin
            n_err++;
            $display("FAIL sticky%0d_end: lat %0d got %b want lat 17 %b", cont, lat, {dll_lock, lock_st}, (cont ? 3'b001 : 3'b110));
        end
    endtask

    task automatic test_edge_votes();
        int lat = 0;
        go_idle();
        rb_lock_win = 2'd0; rb_lock_tol = 4'd15; rb_lock_cnt = 4'd1; rb_cont_cal = 1'b0;
        dll_en = 1'b1;
        for (int i = 0; i < 65; i++) begin
            pd_up = 1'b1; pd_dn = 1'b1;
            step();
            n_vec++;
            if ({dll_lock, lock_st, win_done} !== {m_lock, 2'(m_mode), m_done}) begin
                n_err++;
                $display("FAIL both_high cyc %0d: got %b want %b", i, {dll_lock, lock_st, win_done}, {m_lock, 2'(m_mode), m_done});
            end
        end
        n_vec++;
        if (dll_lock !== 1'b0 || lock_st !== 2'b01) begin
            n_err++;
            $display("FAIL both_high_nolock: got %b%b want 001", dll_lock, lock_st);
        end
        go_idle();
        rb_lock_tol = 4'd2; rb_lock_cnt = 4'd0;
        dll_en = 1'b1;
        for (int i = 0; i < 40 && lat == 0; i++) begin
            pd_up = i[0]; pd_dn = ~i[0];
            step();
            if (dll_lock) lat = i + 1;
        end
        n_vec++;
        if (lat != 17) begin
            n_err++;
            $display("FAIL cnt_zero_latency: got %0d want 17", lat);
        end
    endtask

    task automatic test_disable_locked();
        go_idle();
        rb_lock_win = 2'd0; rb_lock_tol = 4'd2; rb_lock_cnt = 4'd1; rb_cont_cal = 1'b0;
        dll_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pd_up = i[0]; pd_dn = ~i[0];
            step();
        end
        dll_en = 1'b0;
        step();
        n_vec++;
        if ({dll_lock, lock_st, win_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL disable_locked: got %b want 0000", {dll_lock, lock_st, win_done});
        end
    endtask

    task automatic test_rst_mid();
        int lat = 0;
        go_idle();
        rb_lock_win = 2'd0; rb_lock_tol = 4'd2; rb_lock_cnt = 4'd3; rb_cont_cal = 1'b0;
        dll_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            pd_up = i[0]; pd_dn = ~i[0];
            step();
        end
        #2 RSTb = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({dll_lock, lock_st, win_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset: got %b want 0000", {dll_lock, lock_st, win_done});
        end
        step();
        step();
        RSTb = 1'b1;
        for (int i = 0; i < 200 && lat == 0; i++) begin
            pd_up = i[0]; pd_dn = ~i[0];
            step();
            n_vec++;
            if ({dll_lock, lock_st, win_done} !== {m_lock, 2'(m_mode), m_done}) begin
                n_err++;
                $display("FAIL relock cyc %0d: got %b want %b", i, {dll_lock, lock_st, win_done}, {m_lock, 2'(m_mode), m_done});
            end
            if (dll_lock) lat = i + 1;
        end
        n_vec++;
        if (lat != 49) begin
            n_err++;
            $display("FAIL relock_latency: got %0d want 49", lat);
        end
    endtask

    task automatic test_random();
        int mode;
        for (int it = 0; it < 8; it++) begin
            go_idle();
            rb_lock_win = 2'($urandom_range(0, 3));
            rb_lock_tol = 4'($urandom_range(0, 15));
            rb_lock_cnt = 4'($urandom_range(0, 4));
            rb_cont_cal = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 2));
            dll_en = 1'b1;
            for (int i = 0; i < 400; i++) begin
                case (mode)
                    0: begin
                        pd_up = i[0]; pd_dn = ~i[0];
                        if ($urandom_range(0, 9) == 0) pd_dn = 1'b0;
                    end
                    1: begin
                        pd_up = 1'($urandom_range(0, 1)); pd_dn = 1'($urandom_range(0, 1));
                    end
                    default: begin
                        pd_up = ($urandom_range(0, 9) < 6); pd_dn = ~pd_up;
                    end
                endcase
                if (i == 200) begin
                    rb_lock_tol = 4'($urandom_range(0, 15));
                    rb_lock_cnt = 4'($urandom_range(0, 4));
                    rb_cont_cal = 1'($urandom_range(0, 1));
                end
                step();
                n_vec++;
                if ({dll_lock, lock_st, win_done} !== {m_lock, 2'(m_mode), m_done}) begin
                    n_err++;
                    $display("FAIL random it %0d cyc %0d: got %b want %b", it, i, {dll_lock, lock_st, win_done}, {m_lock, 2'(m_mode), m_done});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_unbalanced();
        test_sticky(1'b0);
        test_sticky(1'b1);
        test_edge_votes();
        test_disable_locked();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
